gmii_rx_strip: RTL and testbench

GMII_RX_STRIP -- requirements
Module: gmii_rx_strip

---
 rtl/gmii_rx_strip.sv | 169 ++++++++++++++++
 tb/tb_gmii_rx_strip.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/gmii_rx_strip.sv
// GMII receive front end: strips preamble/SFD, forwards frame bytes one cycle late,
// extracts a 16-bit segment number and reports per-frame status. Define CRC_CHECK_EN to add FCS checking.
module gmii_rx_strip #(
  parameter int SEG_OFFSET = 14,
  parameter int MIN_PRE    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        gmii_rx_dv,
  input  logic        gmii_rx_er,
  input  logic [7:0]  gmii_rxd,
  output logic        rx_en,
  output logic [7:0]  rx_data,
  output logic [15:0] seg,
  output logic        seg_valid,
  output logic        frame_done,
  output logic        frame_err,
  output logic        crc_ok,
  output logic [15:0] byte_len,
  output logic [31:0] frame_count,
  output logic [31:0] err_count
);

  typedef enum logic [1:0] {IDLE, PRE, PAYLOAD, DROP} state_t;

  localparam logic [3:0]  MIN_PRE_L = 4'(MIN_PRE);
  localparam logic [15:0] SEG_MSB_I = 16'(SEG_OFFSET);
  localparam logic [15:0] SEG_LSB_I = 16'(SEG_OFFSET + 1);

  state_t      state, state_n;
  logic [3:0]  pre_cnt;
  logic [15:0] idx;
  logic [7:0]  seg_msb;
  logic        err_flag;
  logic        quiet;
  logic        frame_end;
  logic        abort_err;
  logic        frame_bad;
  logic        crc_good;

`ifdef CRC_CHECK_EN
  logic [31:0] crc;

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++)
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (rst || state != PAYLOAD)
      crc <= 32'hFFFFFFFF;
    else if (gmii_rx_dv)
      crc <= crc_step(crc, gmii_rxd);
  end

  assign crc_good  = (crc == 32'hDEBB20E3);
  assign frame_bad = err_flag | gmii_rx_er | ~crc_good;
`else
  assign crc_good  = 1'b0;
  assign frame_bad = err_flag | gmii_rx_er;
`endif

  // quiet marks the tail of a frame cut by reset: it is dropped without counting
  always_comb begin
    state_n   = state;
    frame_end = 1'b0;
    abort_err = 1'b0;
    case (state)
      IDLE: begin
        if (gmii_rx_dv)
          state_n = (gmii_rxd == 8'h55 && !quiet) ? PRE : DROP;
      end
      PRE: begin
        if (!gmii_rx_dv) begin
          state_n   = IDLE;
          abort_err = 1'b1;
        end else if (gmii_rxd == 8'hD5 && pre_cnt >= MIN_PRE_L) begin
          state_n = PAYLOAD;
        end else if (gmii_rxd != 8'h55) begin
          state_n = DROP;
        end
      end
      PAYLOAD: begin
        if (!gmii_rx_dv) begin
          state_n   = IDLE;
          frame_end = 1'b1;
        end
      end
      DROP: begin
        if (!gmii_rx_dv) begin
          state_n   = IDLE;
          abort_err = ~quiet;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      quiet       <= 1'b1;
      pre_cnt     <= 4'd0;
      idx         <= 16'd0;
      seg_msb     <= 8'd0;
      err_flag    <= 1'b0;
      rx_en       <= 1'b0;
      rx_data     <= 8'd0;
      seg         <= 16'd0;
      seg_valid   <= 1'b0;
      frame_done  <= 1'b0;
      frame_err   <= 1'b0;
      crc_ok      <= 1'b0;
      byte_len    <= 16'd0;
      frame_count <= 32'd0;
      err_count   <= 32'd0;
    end else begin
      state      <= state_n;
      quiet      <= quiet & gmii_rx_dv;
      rx_en      <= 1'b0;
      seg_valid  <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      crc_ok     <= 1'b0;

      if (state == IDLE)
        pre_cnt <= 4'd1;
      else if (state == PRE && gmii_rx_dv && gmii_rxd == 8'h55 && pre_cnt != 4'hF)
        pre_cnt <= pre_cnt + 4'd1;

      if (state == PRE) begin
        idx      <= 16'd0;
        err_flag <= 1'b0;
      end

      if (state == PAYLOAD) begin
        if (gmii_rx_er)
          err_flag <= 1'b1;
        if (gmii_rx_dv) begin
          rx_en   <= 1'b1;
          rx_data <= gmii_rxd;
          if (idx != 16'hFFFF)
            idx <= idx + 16'd1;
          if (idx == SEG_MSB_I)
            seg_msb <= gmii_rxd;
          if (idx == SEG_LSB_I) begin
            seg       <= {seg_msb, gmii_rxd};
            seg_valid <= 1'b1;
          end
        end
      end

      if (frame_end) begin
        frame_done  <= 1'b1;
        frame_err   <= frame_bad;
        crc_ok      <= crc_good;
        byte_len    <= idx;
        frame_count <= frame_count + 32'd1;
      end

      if (abort_err || (frame_end && frame_bad))
        err_count <= err_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_gmii_rx_strip.sv
// Scoreboard bench for gmii_rx_strip: stimulus pushes expected bytes/segments/frame status,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_gmii_rx_strip;

  localparam int SEGO = 14;
`ifdef CRC_CHECK_EN
  localparam bit CRC_MODE = 1'b1;
  localparam int DEF_FCS  = 1;
`else
  localparam bit CRC_MODE = 1'b0;
  localparam int DEF_FCS  = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        gmii_rx_dv = 1'b0;
  logic        gmii_rx_er = 1'b0;
  logic [7:0]  gmii_rxd = 8'h00;
  logic        rx_en;
  logic [7:0]  rx_data;
  logic [15:0] seg;
  logic        seg_valid;
  logic        frame_done;
  logic        frame_err;
  logic        crc_ok;
  logic [15:0] byte_len;
  logic [31:0] frame_count;
  logic [31:0] err_count;

  gmii_rx_strip #(.SEG_OFFSET(SEGO), .MIN_PRE(1)) dut (
    .clk(clk), .rst(rst),
    .gmii_rx_dv(gmii_rx_dv), .gmii_rx_er(gmii_rx_er), .gmii_rxd(gmii_rxd),
    .rx_en(rx_en), .rx_data(rx_data), .seg(seg), .seg_valid(seg_valid),
    .frame_done(frame_done), .frame_err(frame_err), .crc_ok(crc_ok),
    .byte_len(byte_len), .frame_count(frame_count), .err_count(err_count)
  );

  always #4 clk = ~clk;

  typedef struct {
    bit          err;
    bit          ok;
    logic [15:0] len;
  } done_t;

  logic [7:0]  exp_bytes[$];
  logic [15:0] exp_seg[$];
  done_t       exp_done[$];
  int          checks = 0;
  int          passes = 0;
  int          exp_frames = 0;
  int          exp_errs = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  always @(negedge clk) begin
    done_t e;
    if (rx_en) begin
      if (exp_bytes.size() == 0) chk("unexpected_rx_en", 1, 0);
      else chk("rx_data", {24'h0, rx_data}, {24'h0, exp_bytes.pop_front()});
    end
    if (seg_valid) begin
      if (exp_seg.size() == 0) chk("unexpected_seg_valid", 1, 0);
      else chk("seg", {16'h0, seg}, {16'h0, exp_seg.pop_front()});
    end
    if (frame_done) begin
      if (exp_done.size() == 0) chk("unexpected_frame_done", 1, 0);
      else begin
        e = exp_done.pop_front();
        chk("frame_err", {31'h0, frame_err}, {31'h0, e.err});
        chk("crc_ok", {31'h0, crc_ok}, {31'h0, e.ok});
        chk("byte_len", {16'h0, byte_len}, {16'h0, e.len});
      end
    end else if (frame_err || crc_ok) begin
      chk("qualifier_without_done", 1, 0);
    end
  end

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  task automatic drive(input bit dv, input bit er, input logic [7:0] d);
    @(posedge clk); #1;
    gmii_rx_dv = dv; gmii_rx_er = er; gmii_rxd = d;
  endtask

  task automatic idle_and_drain(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 8'h00);
    chk("bytes_drained", exp_bytes.size(), 0);
    chk("segs_drained", exp_seg.size(), 0);
    chk("done_drained", exp_done.size(), 0);
  endtask

  task automatic check_counts();
    chk("frame_count", frame_count, exp_frames);
    chk("err_count", err_count, exp_errs);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; gmii_rx_dv = 0; gmii_rx_er = 0; gmii_rxd = 8'h00;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    exp_frames = 0;
    exp_errs = 0;
  endtask

  // fcs_mode: 0 none, 1 correct FCS appended, 2 FCS with last byte flipped
  task automatic send_frame(input int npre, input int nbody, input int er_at, input int fcs_mode);
    logic [31:0] c, fcs;
    logic [7:0]  b, msb;
    int          total;
    done_t       e;
    c = 32'hFFFFFFFF; fcs = 32'h0; msb = 8'h00;
    total = nbody + ((fcs_mode != 0) ? 4 : 0);
    for (int i = 0; i < npre; i++) drive(1, 0, 8'h55);
    drive(1, 0, 8'hD5);
    for (int i = 0; i < total; i++) begin
      if (i == nbody) fcs = ~c;
      if (i < nbody) begin
        b = 8'(i);
        c = crc_upd(c, b);
      end else begin
        b = fcs[8*(i-nbody) +: 8];
        if (fcs_mode == 2 && i == total - 1) b = b ^ 8'h01;
      end
      exp_bytes.push_back(b);
      if (i == SEGO) msb = b;
      if (i == SEGO + 1) exp_seg.push_back({msb, b});
      drive(1, (i == er_at), b);
    end
    e.err = (er_at >= 0 && er_at < total) || (CRC_MODE && fcs_mode != 1);
    e.ok  = CRC_MODE && fcs_mode == 1;
    e.len = 16'(total);
    exp_done.push_back(e);
    exp_frames++;
    if (e.err) exp_errs++;
    idle_and_drain(4);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_rx_en", {31'h0, rx_en}, 0);
    chk("rst_seg", {16'h0, seg}, 0);
    chk("rst_byte_len", {16'h0, byte_len}, 0);
    chk("rst_frame_done", {31'h0, frame_done}, 0);
    check_counts();

    // Long preamble, 64 bytes 0x00..0x3F
    send_frame(7, 64, -1, DEF_FCS);
    chk("seg_after_64", {16'h0, seg}, 32'h0E0F);
    check_counts();

    // Bad preamble byte 0x54 then 20 bytes: dropped
    do_reset();
    drive(1, 0, 8'h55); drive(1, 0, 8'h54); drive(1, 0, 8'hD5);
    for (int i = 0; i < 20; i++) drive(1, 0, 8'(i));
    exp_errs++;
    idle_and_drain(4);
    check_counts();

    // rx_er at byte 5: bytes still delivered, frame flagged
    do_reset();
    send_frame(7, 32, 5, DEF_FCS);
    check_counts();

    // 10-byte frame keeps previous seg
    send_frame(7, 10, -1, 0);
    chk("seg_held", {16'h0, seg}, 32'h0E0F);
    check_counts();

    // SFD with no preamble, and preamble cut by dv low
    drive(1, 0, 8'hD5);
    for (int i = 0; i < 5; i++) drive(1, 0, 8'h55);
    exp_errs++;
    idle_and_drain(3);
    drive(1, 0, 8'h55); drive(1, 0, 8'h55);
    exp_errs++;
    idle_and_drain(3);
    check_counts();

    // Minimum preamble of one byte
    send_frame(1, 16, -1, DEF_FCS);
    check_counts();

    // Reset at byte 30 with dv staying high
    do_reset();
    for (int i = 0; i < 7; i++) drive(1, 0, 8'h55);
    drive(1, 0, 8'hD5);
    for (int i = 0; i < 30; i++) begin
      exp_bytes.push_back(8'(i));
      if (i == SEGO + 1) exp_seg.push_back(16'h0E0F);
      drive(1, 0, 8'(i));
    end
    @(posedge clk); #1;
    rst = 1'b1; gmii_rxd = 8'd30;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 31; i < 60; i++) drive(1, 0, 8'(i));
    exp_frames = 0;
    exp_errs = 0;
    idle_and_drain(4);
    chk("seg_after_reset", {16'h0, seg}, 0);
    check_counts();
    send_frame(7, 20, -1, DEF_FCS);
    check_counts();

`ifdef CRC_CHECK_EN
    send_frame(7, 60, -1, 1);
    send_frame(7, 60, -1, 2);
    check_counts();
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
